// File: rtl/axi4_burst_ram_slave.sv
// AXI4 slave backed by an on-chip word memory: full bursts (FIXED/INCR/WRAP), byte strobes,
// one outstanding transaction per direction, SLVERR for unmapped beats and illegal bursts.
module axi4_burst_ram_slave #(
  parameter int unsigned N         = 8,
  parameter int unsigned I         = 8,
  parameter int unsigned A         = 32,
  parameter int unsigned DEPTH     = 256,
  parameter logic [A-1:0] BASE_ADDR = A'(32'h0000_1000)
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic [I-1:0]   AWID,
  input  logic [A-1:0]   AWADDR,
  input  logic [7:0]     AWLEN,
  input  logic [2:0]     AWSIZE,
  input  logic [1:0]     AWBURST,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  output logic [I-1:0]   BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  input  logic [I-1:0]   ARID,
  input  logic [A-1:0]   ARADDR,
  input  logic [7:0]     ARLEN,
  input  logic [2:0]     ARSIZE,
  input  logic [1:0]     ARBURST,
  input  logic           ARVALID,
  output logic           ARREADY,
  output logic [I-1:0]   RID,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY
);
  localparam int unsigned DW = 8 * N;
  localparam int unsigned LN = $clog2(N);
  localparam int unsigned WW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A:0]  LIMIT = (A+1)'(BASE_ADDR) + (A+1)'(DEPTH * N);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  typedef struct packed {
    logic [I-1:0] id;
    logic [A-1:0] addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic [7:0]   cnt;
    logic         bad;
  } burst_t;

  logic [DW-1:0] mem [DEPTH];

  w_state_e w_state, w_state_n;
  r_state_e r_state, r_state_n;
  burst_t   w_ctx, w_ctx_n, r_ctx, r_ctx_n;
  logic     w_err, w_err_n, w_beat_ok, mem_we;
  logic [WW-1:0] w_word;
  logic [I-1:0]  bid_n, rid_n;
  logic [1:0]    bresp_n, rresp_n;
  logic [DW-1:0] rdata_n, ld_data;
  logic [A-1:0]  ld_addr;
  logic          rvalid_n, rlast_n, ld_ok;

  function automatic logic in_range(input logic [A-1:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  endfunction

  function automatic logic [WW-1:0] word_idx(input logic [A-1:0] addr);
    logic [A-1:0] off;
    off = addr - BASE_ADDR;
    return WW'(off >> LN);
  endfunction

  function automatic logic illegal(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || (size > 3'(LN)) || bad_wrap;
  endfunction

  // Address of the following beat; WRAP folds back to the start of its container.
  function automatic logic [A-1:0] next_addr(input logic [A-1:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
    logic [A-1:0] step, incr, wbytes, wbase;
    step   = A'(1) << size;
    incr   = (addr & ~(step - A'(1))) + step;
    wbytes = A'({1'b0, len} + 9'd1) << size;
    wbase  = addr & ~(wbytes - A'(1));
    case (burst)
      2'b00:   return addr;
      2'b10:   return (incr == wbase + wbytes) ? wbase : incr;
      default: return incr;
    endcase
  endfunction

  assign w_word    = word_idx(w_ctx.addr);
  assign w_beat_ok = !w_ctx.bad && in_range(w_ctx.addr);

  // Write channel next-state
  always_comb begin
    w_state_n = w_state;
    w_ctx_n   = w_ctx;
    w_err_n   = w_err;
    bid_n     = BID;
    bresp_n   = BRESP;
    mem_we    = 1'b0;
    unique case (w_state)
      W_IDLE: if (AWVALID && AWREADY) begin
        w_ctx_n   = '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE, burst: AWBURST,
                      cnt: 8'd0, bad: illegal(AWLEN, AWSIZE, AWBURST)};
        w_err_n   = 1'b0;
        w_state_n = W_DATA;
      end
      W_DATA: if (WVALID && WREADY) begin
        mem_we = w_beat_ok;
        if (!w_beat_ok || (WLAST != (w_ctx.cnt == w_ctx.len))) w_err_n = 1'b1;
        w_ctx_n.addr = next_addr(w_ctx.addr, w_ctx.len, w_ctx.size, w_ctx.burst);
        w_ctx_n.cnt  = w_ctx.cnt + 8'd1;
        if (w_ctx.cnt == w_ctx.len) begin
          w_state_n = W_RESP;
          bid_n     = w_ctx.id;
          bresp_n   = w_err_n ? 2'b10 : 2'b00;
        end
      end
      W_RESP: if (BVALID && BREADY) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
    end else begin
      w_state <= w_state_n;
      AWREADY <= (w_state_n == W_IDLE);
      WREADY  <= (w_state_n == W_DATA);
      BVALID  <= (w_state_n == W_RESP);
      BID     <= bid_n;
      BRESP   <= bresp_n;
      w_ctx   <= w_ctx_n;
      w_err   <= w_err_n;
    end
  end

  // Memory contents survive reset; an abandoned burst writes nothing on the reset edge.
  always_ff @(posedge ACLK) begin
    if (mem_we && !ARESET) begin
      for (int unsigned b = 0; b < N; b++) begin
        if (WSTRB[b]) mem[w_word][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // Beat to load: from the AR payload in idle, else from the running context.
  assign ld_addr = (r_state == R_IDLE) ? ARADDR : r_ctx.addr;
  assign ld_ok   = (r_state == R_IDLE) ? (!illegal(ARLEN, ARSIZE, ARBURST) && in_range(ARADDR))
                                       : (!r_ctx.bad && in_range(r_ctx.addr));
  assign ld_data = ld_ok ? mem[word_idx(ld_addr)] : '0;

  // Read channel next-state
  always_comb begin
    r_state_n = r_state;
    r_ctx_n   = r_ctx;
    rid_n     = RID;
    rdata_n   = RDATA;
    rresp_n   = RRESP;
    rlast_n   = RLAST;
    rvalid_n  = RVALID;
    unique case (r_state)
      R_IDLE: if (ARVALID && ARREADY) begin
        r_ctx_n   = '{id: ARID, addr: next_addr(ARADDR, ARLEN, ARSIZE, ARBURST), len: ARLEN,
                      size: ARSIZE, burst: ARBURST, cnt: 8'd1,
                      bad: illegal(ARLEN, ARSIZE, ARBURST)};
        rid_n     = ARID;
        rdata_n   = ld_data;
        rresp_n   = ld_ok ? 2'b00 : 2'b10;
        rlast_n   = (ARLEN == 8'd0);
        rvalid_n  = 1'b1;
        r_state_n = R_DATA;
      end
      R_DATA: if (RVALID && RREADY) begin
        if (RLAST) begin
          rvalid_n  = 1'b0;
          rlast_n   = 1'b0;
          r_state_n = R_IDLE;
        end else begin
          rdata_n      = ld_data;
          rresp_n      = ld_ok ? 2'b00 : 2'b10;
          rlast_n      = (r_ctx.cnt == r_ctx.len);
          r_ctx_n.addr = next_addr(r_ctx.addr, r_ctx.len, r_ctx.size, r_ctx.burst);
          r_ctx_n.cnt  = r_ctx.cnt + 8'd1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
    end else begin
      r_state <= r_state_n;
      ARREADY <= (r_state_n == R_IDLE);
      RVALID  <= rvalid_n;
      RLAST   <= rlast_n;
      RID     <= rid_n;
      RDATA   <= rdata_n;
      RRESP   <= rresp_n;
      r_ctx   <= r_ctx_n;
    end
  end

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Directed bench for axi4_burst_ram_slave at default parameters (64-bit bus, 256 words at 0x1000).
module tb_axi4_burst_ram_slave;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  axi4_burst_ram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic        wl [16];
  logic [7:0]  b_id;
  logic [1:0]  b_resp;
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [7:0]  rd_id [16];
  int          rd_cyc [16];
  int          rd_wait0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_beats(input int len);
    for (int i = 0; i < 16; i++) begin
      wl[i] = (i == len);
      ws[i] = 8'hFF;
    end
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (!AWREADY && t < 100) begin @(negedge ACLK); t++; end
    if (t >= 100) check("aw_timeout", 64'(t), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && t < 100) begin @(negedge ACLK); t++; end
    if (t >= 100) check("ar_timeout", 64'(t), 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  // Burst of len+1 beats from wd/ws/wl, then collect the B response.
  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int t;
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = wl[i]; WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) check("w_timeout", 64'(t), 64'd0);
      @(posedge ACLK);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(negedge ACLK); t++; end
    if (t >= 100) check("b_timeout", 64'(t), 64'd0);
    b_id = BID; b_resp = BRESP;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  // Read with RREADY held high; records each beat and the cycle it was seen.
  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int t;
    RREADY = 1'b1;
    do_ar(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!RVALID && t < 100) begin @(negedge ACLK); t++; end
      if (t >= 100) check("r_timeout", 64'(t), 64'd0);
      if (i == 0) rd_wait0 = t;
      rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST; rd_id[i] = RID;
      rd_cyc[i] = cyc;
      @(posedge ACLK);
      @(negedge ACLK);
    end
    RREADY = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_wrap [4];
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rlast", 64'(RLAST), 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("idle_awready", 64'(AWREADY), 64'd1);
    check("idle_arready", 64'(ARREADY), 64'd1);

    // Single-beat write and read-back
    set_beats(0);
    wd[0] = 64'hDEAD_BEEF_1234_5678;
    write_burst(8'h00, 32'h1000, 8'd0, 3'd3, 2'b01);
    check("t1_bid", 64'(b_id), 64'h00);
    check("t1_bresp", 64'(b_resp), 64'd0);
    read_burst(8'h00, 32'h1000, 8'd0, 3'd3, 2'b01);
    check("t1_rdata", rd_data[0], 64'hDEAD_BEEF_1234_5678);
    check("t1_rresp", 64'(rd_resp[0]), 64'd0);
    check("t1_rlast", 64'(rd_last[0]), 64'd1);
    check("t1_rid", 64'(rd_id[0]), 64'h00);
    check("t1_rlatency", 64'(rd_wait0), 64'd0);

    // INCR len=3, back-to-back read beats
    set_beats(3);
    for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
    write_burst(8'h03, 32'h1000, 8'd3, 3'd3, 2'b01);
    check("t2_bid", 64'(b_id), 64'h03);
    check("t2_bresp", 64'(b_resp), 64'd0);
    read_burst(8'h5A, 32'h1000, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rdata%0d", i), rd_data[i], 64'(i + 1));
      check($sformatf("t2_rlast%0d", i), 64'(rd_last[i]), 64'(i == 3));
      check($sformatf("t2_rid%0d", i), 64'(rd_id[i]), 64'h5A);
      check($sformatf("t2_cycle%0d", i), 64'(rd_cyc[i] - rd_cyc[0]), 64'(i));
    end

    // WRAP len=3 from 0x1010 visits 0x1010, 0x1018, 0x1000, 0x1008
    exp_wrap[0] = 64'd3; exp_wrap[1] = 64'd4; exp_wrap[2] = 64'd1; exp_wrap[3] = 64'd2;
    read_burst(8'h07, 32'h1010, 8'd3, 3'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_wrap%0d", i), rd_data[i], exp_wrap[i]);
      check($sformatf("t3_wresp%0d", i), 64'(rd_resp[i]), 64'd0);
    end
    set_beats(2);
    wd[0] = 64'hA1; wd[1] = 64'hA2; wd[2] = 64'hA3;
    write_burst(8'h01, 32'h1000, 8'd2, 3'd3, 2'b00);
    check("t3_fixed_bresp", 64'(b_resp), 64'd0);
    read_burst(8'h01, 32'h1000, 8'd1, 3'd3, 2'b01);
    check("t3_fixed_word0", rd_data[0], 64'hA3);
    check("t3_fixed_word1", rd_data[1], 64'd2);

    // Out-of-range write must not alias onto word 0
    set_beats(0);
    wd[0] = 64'h5555_5555_5555_5555;
    write_burst(8'h02, 32'h1800, 8'd0, 3'd3, 2'b01);
    check("t4_oor_bresp", 64'(b_resp), 64'd2);
    read_burst(8'h02, 32'h1000, 8'd0, 3'd3, 2'b01);
    check("t4_unchanged", rd_data[0], 64'hA3);
    wd[0] = 64'h77;
    write_burst(8'h02, 32'h17F8, 8'd0, 3'd3, 2'b01);
    check("t4_top_bresp", 64'(b_resp), 64'd0);
    read_burst(8'h09, 32'h17F8, 8'd1, 3'd3, 2'b01);
    check("t4_b0_data", rd_data[0], 64'h77);
    check("t4_b0_resp", 64'(rd_resp[0]), 64'd0);
    check("t4_b1_data", rd_data[1], 64'd0);
    check("t4_b1_resp", 64'(rd_resp[1]), 64'd2);
    check("t4_b1_last", 64'(rd_last[1]), 64'd1);

    // Partial strobe, WLAST mismatch, reserved burst type
    wd[0] = 64'hDEAD_BEEF_1234_5678;
    write_burst(8'h04, 32'h1020, 8'd0, 3'd3, 2'b01);
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F;
    write_burst(8'h04, 32'h1020, 8'd0, 3'd3, 2'b01);
    check("t5_strb_bresp", 64'(b_resp), 64'd0);
    read_burst(8'h04, 32'h1020, 8'd0, 3'd3, 2'b01);
    check("t5_strb_data", rd_data[0], 64'hDEAD_BEEF_FFFF_FFFF);
    set_beats(1);
    wl[0] = 1'b1;
    wd[0] = 64'h11; wd[1] = 64'h22;
    write_burst(8'h0C, 32'h1028, 8'd1, 3'd3, 2'b01);
    check("t5_wlast_bresp", 64'(b_resp), 64'd2);
    check("t5_wlast_bid", 64'(b_id), 64'h0C);
    set_beats(0);
    wd[0] = 64'hBAD;
    write_burst(8'h0D, 32'h1000, 8'd0, 3'd3, 2'b11);
    check("t5_rsvd_bresp", 64'(b_resp), 64'd2);
    read_burst(8'h0D, 32'h1000, 8'd0, 3'd3, 2'b11);
    check("t5_rsvd_rdata", rd_data[0], 64'd0);
    check("t5_rsvd_rresp", 64'(rd_resp[0]), 64'd2);
    read_burst(8'h0D, 32'h1000, 8'd0, 3'd3, 2'b01);
    check("t5_rsvd_nowrite", rd_data[0], 64'hA3);

    // Reset while beat 2 of 4 is stalled
    RREADY = 1'b0;
    do_ar(8'h66, 32'h1000, 8'd3, 3'd3, 2'b01);
    check("t6_beat0_valid", 64'(RVALID), 64'd1);
    RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("t6_beat2_data", RDATA, 64'd3);
    check("t6_beat2_valid", 64'(RVALID), 64'd1);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("t6_rst_rvalid", 64'(RVALID), 64'd0);
    check("t6_rst_rlast", 64'(RLAST), 64'd0);
    ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("t6_post_arready", 64'(ARREADY), 64'd1);
    check("t6_post_rvalid", 64'(RVALID), 64'd0);
    read_burst(8'h0E, 32'h1010, 8'd0, 3'd3, 2'b01);
    check("t6_retained", rd_data[0], 64'd3);
    check("t6_retained_id", 64'(rd_id[0]), 64'h0E);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
